// File: rtl/codec_config_sequencer.sv
// Walks a fixed audio-codec register table through an I2C byte-transfer controller, with retry on NACK.
// Optional macro CODEC_POWERUP_DELAY_EN: hold POWERUP_TICKS slow ticks after reset before the first write.
module codec_config_sequencer #(
    parameter int unsigned CLK_FREQ      = 50000000,
    parameter int unsigned I2C_FREQ      = 20000,
    parameter logic [7:0]  SLAVE_ADDR    = 8'h34,
    parameter int unsigned LUT_SIZE      = 10,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned POWERUP_TICKS = 2000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        RECONFIG,
    output logic        I2C_CTRL_CLK,
    output logic [23:0] I2C_DATA,
    output logic        GO,
    input  logic        END,
    input  logic [2:0]  ACK,
    output logic [3:0]  INDEX,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR
);

    localparam int unsigned DIV    = CLK_FREQ / (2 * I2C_FREQ);
    localparam int unsigned CNT_W  = $clog2(DIV);
    localparam int unsigned HOLD_W = $clog2(POWERUP_TICKS + 2);
    localparam int unsigned RTY_W  = $clog2(MAX_RETRY + 2);
`ifdef CODEC_POWERUP_DELAY_EN
    localparam int unsigned HOLD_TICKS = POWERUP_TICKS;
`else
    localparam int unsigned HOLD_TICKS = 1;
`endif

    typedef enum logic [2:0] {S_HOLD, S_GAP, S_XFER, S_CHECK, S_FINISH, S_FAIL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic               sclk_q, sclk_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [1:0]         step_q, step_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [3:0]         index_q, index_d;
    logic [23:0]        data_q, data_d;
    logic               go_q, go_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               rcfg_q, rcfg_d;
    logic               tick_c;
    logic               rcfg_c;

    function automatic logic [15:0] lut_f(input logic [3:0] idx);
        case (idx)
            4'd0:    lut_f = 16'h001A;
            4'd1:    lut_f = 16'h021A;
            4'd2:    lut_f = 16'h047B;
            4'd3:    lut_f = 16'h067B;
            4'd4:    lut_f = 16'h08F8;
            4'd5:    lut_f = 16'h0A06;
            4'd6:    lut_f = 16'h0C00;
            4'd7:    lut_f = 16'h0E01;
            4'd8:    lut_f = 16'h1002;
            4'd9:    lut_f = 16'h1201;
            default: lut_f = 16'h0000;
        endcase
    endfunction

    // A tick is the system cycle in which the slow clock falls.
    assign tick_c = sclk_q && (div_q == CNT_W'(DIV - 1));
    assign rcfg_c = rcfg_q | RECONFIG;

    always_comb begin
        state_d = state_q;
        div_d   = div_q + CNT_W'(1);
        sclk_d  = sclk_q;
        hold_d  = hold_q;
        step_d  = step_q;
        retry_d = retry_q;
        index_d = index_q;
        data_d  = data_q;
        go_d    = go_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
        rcfg_d  = tick_c ? 1'b0 : rcfg_c;

        if (div_q == CNT_W'(DIV - 1)) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
        end

        if (tick_c) begin
            case (state_q)
                S_HOLD: begin
                    go_d = 1'b0;
                    if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
                        hold_d  = '0;
                        step_d  = '0;
                        state_d = S_GAP;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                // Two ticks with GO low let the controller rewind its bit counter.
                S_GAP: begin
                    go_d   = 1'b0;
                    data_d = {SLAVE_ADDR, lut_f(index_q)};
                    if (step_q == 2'd1) begin
                        step_d  = '0;
                        state_d = S_XFER;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
                // END may still be stale from the previous write during the first two ticks.
                S_XFER: begin
                    go_d = 1'b1;
                    if (step_q != 2'd2) begin
                        step_d = step_q + 2'd1;
                    end else if (END) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    step_d = '0;
                    if (ACK == 3'b000) begin
                        retry_d = '0;
                        if (index_q == 4'(LUT_SIZE - 1)) begin
                            go_d    = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_FINISH;
                        end else begin
                            index_d = index_q + 4'd1;
                            state_d = S_GAP;
                        end
                    end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = S_GAP;
                    end else begin
                        go_d    = 1'b0;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                        state_d = S_FAIL;
                    end
                end
                S_FINISH, S_FAIL: begin
                    go_d = 1'b0;
                    if (rcfg_c) begin
                        done_d  = 1'b0;
                        error_d = 1'b0;
                        index_d = '0;
                        retry_d = '0;
                        busy_d  = 1'b1;
                        step_d  = '0;
                        state_d = S_GAP;
                    end
                end
                default: state_d = S_HOLD;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_HOLD;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            hold_q  <= '0;
            step_q  <= '0;
            retry_q <= '0;
            index_q <= '0;
            data_q  <= '0;
            go_q    <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            rcfg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            hold_q  <= hold_d;
            step_q  <= step_d;
            retry_q <= retry_d;
            index_q <= index_d;
            data_q  <= data_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            rcfg_q  <= rcfg_d;
        end
    end

    assign I2C_CTRL_CLK = sclk_q;
    assign I2C_DATA     = data_q;
    assign GO           = go_q;
    assign INDEX        = index_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign ERROR        = error_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer with a behavioural I2C controller model (END 33 slow cycles after GO).
module tb_codec_config_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reconfig = 1'b0;
    logic        sclk;
    logic [23:0] data;
    logic        go;
    logic        end_i = 1'b0;
    logic [2:0]  ack_i = 3'b000;
    logic [3:0]  index;
    logic        busy, done, error;

    always #5 clk = ~clk;

    codec_config_sequencer #(
        .CLK_FREQ(8), .I2C_FREQ(1), .SLAVE_ADDR(8'h34),
        .LUT_SIZE(10), .MAX_RETRY(3), .POWERUP_TICKS(5)
    ) dut (
        .CLOCK(clk), .RESET(rst), .RECONFIG(reconfig),
        .I2C_CTRL_CLK(sclk), .I2C_DATA(data), .GO(go),
        .END(end_i), .ACK(ack_i), .INDEX(index),
        .BUSY(busy), .DONE(done), .ERROR(error)
    );

`ifdef CODEC_POWERUP_DELAY_EN
    localparam int EXP_GO_TICK = 8;
`else
    localparam int EXP_GO_TICK = 4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [23:0] exp_tab [10] = '{24'h34001A, 24'h34021A, 24'h34047B, 24'h34067B, 24'h3408F8,
                                  24'h340A06, 24'h340C00, 24'h340E01, 24'h341002, 24'h341201};

    // Controller model: records each transfer and answers with the ACK chosen by the test mode.
    int          mode = 0;
    int          att [16];
    logic [23:0] xfer_log [$];
    int          ccnt = 0;
    logic        clr_req = 1'b0;
    logic        sclk_prev = 1'b0;

    function automatic logic [2:0] ack_policy(input int m, input int idx, input int a);
        if (m == 1 && idx == 4 && a == 0) return 3'b010;
        if (m == 2 && idx == 2) return 3'b001;
        return 3'b000;
    endfunction

    always @(negedge clk) begin
        sclk_prev <= sclk;
        if (rst || clr_req) begin
            ccnt  <= 0;
            end_i <= 1'b0;
            ack_i <= 3'b000;
            foreach (att[i]) att[i] = 0;
            xfer_log.delete();
        end else if (sclk && !sclk_prev) begin
            if (!go) begin
                ccnt  <= 0;
                end_i <= 1'b0;
            end else begin
                if (ccnt == 0) begin
                    xfer_log.push_back(data);
                    ack_i <= ack_policy(mode, int'(index), att[index]);
                    att[index] = att[index] + 1;
                end
                if (ccnt < 33) ccnt <= ccnt + 1;
                if (ccnt == 32) end_i <= 1'b1;
            end
        end
    end

    // Shortest run of low-GO ticks between two consecutive GO pulses.
    int   min_gap = 1000;
    int   low_run = 0;
    bit   had_go = 1'b0;
    logic mon_prev = 1'b0;
    logic go_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            had_go  = 1'b0;
            low_run = 0;
            go_prev = 1'b0;
        end else if (mon_prev && !sclk) begin
            if (!go) begin
                low_run++;
            end else if (!go_prev) begin
                if (had_go && low_run < min_gap) min_gap = low_run;
                had_go  = 1'b1;
                low_run = 0;
            end
            go_prev = go;
        end
        mon_prev = sclk;
    end

    task automatic do_reset(input int m);
        @(posedge clk); #1;
        rst  = 1'b1;
        mode = m;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(done || error) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 20000), 32'd1);
    endtask

    task automatic pulse_reconfig();
        @(posedge clk); #1 reconfig = 1'b1;
        @(posedge clk); #1 reconfig = 1'b0;
    endtask

    task automatic check_full_log(input string tag);
        check({tag, "_count"}, 32'(xfer_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < xfer_log.size(); i++)
            check($sformatf("%s_entry%0d", tag, i), 32'(xfer_log[i]), 32'(exp_tab[i]));
    endtask

    initial begin
        int n;
        int ticks;
        logic prev;
        logic [23:0] exp_q [$];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_go", 32'(go), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_index", 32'(index), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        rst = 1'b0;

        // Divider: DIV=4 gives first rise after 4 clocks, then 4 high / 4 low
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!sclk && n < 50);
        check("first_rise", 32'(n), 32'd4);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (sclk && n < 50);
        check("high_len", 32'(n), 32'd4);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!sclk && n < 50);
        check("low_len", 32'(n), 32'd4);

        ticks = 1;
        prev  = sclk;
        n     = 0;
        do begin
            @(posedge clk); #1; n++;
            if (prev && !sclk) ticks++;
            prev = sclk;
        end while (!go && n < 500);
        check("first_go_tick", 32'(ticks), 32'(EXP_GO_TICK));
        check("first_go_data", 32'(data), 32'h34001A);

        // All writes acknowledged
        wait_idle("run0");
        check("run0_done", 32'(done), 32'd1);
        check("run0_busy", 32'(busy), 32'd0);
        check("run0_error", 32'(error), 32'd0);
        check("run0_go", 32'(go), 32'd0);
        check("run0_index", 32'(index), 32'd9);
        check_full_log("run0");
        check("go_gap_ticks", 32'(min_gap), 32'd2);

        // One NACK on entry 4, then success
        do_reset(1);
        wait_idle("run1");
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(exp_tab[i]);
            if (i == 4) exp_q.push_back(exp_tab[i]);
        end
        check("run1_count", 32'(xfer_log.size()), 32'd11);
        for (int i = 0; i < 11 && i < xfer_log.size(); i++)
            check($sformatf("run1_entry%0d", i), 32'(xfer_log[i]), 32'(exp_q[i]));
        check("run1_done", 32'(done), 32'd1);
        check("run1_error", 32'(error), 32'd0);

        // Persistent NACK on entry 2 exhausts the retries
        do_reset(2);
        wait_idle("run2");
        check("run2_error", 32'(error), 32'd1);
        check("run2_index", 32'(index), 32'd2);
        check("run2_done", 32'(done), 32'd0);
        check("run2_go", 32'(go), 32'd0);
        check("run2_busy", 32'(busy), 32'd0);
        check("run2_count", 32'(xfer_log.size()), 32'd6);
        check("run2_attempts", 32'(att[2]), 32'd4);
        if (xfer_log.size() == 6)
            check("run2_last_data", 32'(xfer_log[5]), 32'h34047B);

        // RECONFIG from FAIL restarts at entry 0
        mode = 0;
        @(posedge clk); #1 clr_req = 1'b1;
        @(negedge clk); #1 clr_req = 1'b0;
        pulse_reconfig();
        repeat (12) @(posedge clk);
        #1;
        check("rcfg_error", 32'(error), 32'd0);
        check("rcfg_busy", 32'(busy), 32'd1);
        check("rcfg_index", 32'(index), 32'd0);
        check("rcfg_done", 32'(done), 32'd0);
        wait_idle("rcfg");
        check("rcfg_run_done", 32'(done), 32'd1);
        check_full_log("rcfg");

        // RECONFIG while busy is ignored; reset mid-transfer aborts and restarts
        do_reset(0);
        n = 0;
        while (index != 4'd3 && n < 20000) begin @(posedge clk); #1; n++; end
        check("wait_idx3", 32'(index), 32'd3);
        pulse_reconfig();
        repeat (20) @(posedge clk);
        #1;
        check("busy_rcfg_index", 32'(index), 32'd3);
        check("busy_rcfg_busy", 32'(busy), 32'd1);
        n = 0;
        while (!(index == 4'd6 && go) && n < 20000) begin @(posedge clk); #1; n++; end
        check("wait_idx6_go", 32'(go), 32'd1);
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_go", 32'(go), 32'd0);
        check("midrst_index", 32'(index), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_busy", 32'(busy), 32'd1);
        check("midrst_data", 32'(data), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        wait_idle("midrst");
        check("midrst_run_done", 32'(done), 32'd1);
        check_full_log("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/codec_config_sequencer.md
Name: codec_config_sequencer

Overview:
- Sits directly upstream of the I2C byte-transfer controller in the audio path.
- Generates that controller's slow clock from the system clock.
- Walks a fixed table of audio-codec register writes, presenting each write as a 24-bit {slave addr, reg addr, data} word with a GO/END handshake.
- Checks the three ACK bits of each write, retries failed writes, and reports DONE or ERROR to the rest of the system.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- I2C_FREQ, 20000: controller clock frequency in Hz. DIV = CLK_FREQ/(2*I2C_FREQ) must be an integer ≥ 2.
- SLAVE_ADDR, 8'h34: codec write address; forms bits [23:16] of I2C_DATA.
- LUT_SIZE, 10: number of table entries, 1..16.
- MAX_RETRY, 3: extra attempts per entry after a NACK.
- POWERUP_TICKS, 2000: hold-off length in slow ticks; used only with the optional feature.

Ports:
- CLOCK  in  1: system clock. All logic is on the rising edge.
- RESET  in  1: synchronous, active-high reset.
- RECONFIG  in  1: one-CLOCK pulse; restarts the sequence when the block is idle.
- I2C_CTRL_CLK  out  1: clock driven to the controller's CLOCK input.
- I2C_DATA  out  24: {SLAVE_ADDR, LUT[INDEX]} to the controller.
- GO  out  1: transfer request to the controller.
- END  in  1: transfer complete, from the controller.
- ACK  in  3: {addr, sub-addr, data} ACK bits from the controller; 0 means acknowledged.
- INDEX  out  4: current table entry.
- BUSY  out  1: sequence in progress.
- DONE  out  1: all entries written successfully.
- ERROR  out  1: an entry failed after all retries.

Behaviour:
- Divider
  - 0..DIV-1 counter; I2C_CTRL_CLK toggles at each wrap.
  - A "tick" is the CLOCK cycle in which I2C_CTRL_CLK toggles 1->0.
  - All FSM transitions, output updates and END/ACK sampling happen only on ticks. Outputs are therefore stable half a slow period before the controller's rising edge.
- LUT (16-bit {reg addr 7b, data 9b}), entries 0..9:
  - 0x001A, 0x021A, 0x047B, 0x067B, 0x08F8, 0x0A06, 0x0C00, 0x0E01, 0x1002, 0x1201.
  - Entries at index ≥ LUT_SIZE are never issued.
- Reset values:
  - Divider = 0; I2C_CTRL_CLK = 0; GO = 0; I2C_DATA = 0; INDEX = 0.
  - BUSY = 1; DONE = 0; ERROR = 0; retry count = 0; state = HOLD.
- FSM states:
  - HOLD: next tick -> GAP. With the optional feature, HOLD instead waits POWERUP_TICKS ticks.
  - GAP: GO = 0 for exactly 2 ticks, so the controller's counter reaches 0; I2C_DATA loads {SLAVE_ADDR, LUT[INDEX]}; then -> XFER.
  - XFER: GO = 1. END is ignored for the first 2 ticks (holdoff). After that, the first tick with END = 1 -> CHECK.
  - CHECK:
    - ACK == 3'b000: retry count = 0. If INDEX == LUT_SIZE-1 -> FINISH; else INDEX+1 -> GAP.
    - ACK != 0 and retry count < MAX_RETRY: retry count+1, INDEX unchanged -> GAP.
    - Otherwise -> FAIL.
  - FINISH: GO = 0, BUSY = 0, DONE = 1. Sticky.
  - FAIL: GO = 0, BUSY = 0, ERROR = 1. Sticky. INDEX holds the failing entry.
- GO stays high through CHECK and drops in GAP. Each transfer takes 33 controller cycles plus 2 gap ticks.
- RECONFIG:
  - Sampled on every CLOCK and latched until the next tick.
  - In FINISH or FAIL: on that tick, clear DONE/ERROR/INDEX/retry count, set BUSY = 1, -> GAP. No power-up hold-off.
  - In any other state: dropped, no effect.
- Reset mid-transfer: GO drops to 0 on the same edge, aborting the controller. The sequence restarts from HOLD.
- Timeout: none. A controller that never raises END leaves the block in XFER.

Optional Feature:
- Macro: CODEC_POWERUP_DELAY_EN.
- Defined: HOLD counts POWERUP_TICKS ticks (100 ms at the defaults) before entering GAP, after every reset.
- Undefined: HOLD lasts 1 tick, and POWERUP_TICKS is unused.

Test Plan:
- CLK_FREQ=8, I2C_FREQ=1 (DIV=4): after reset, I2C_CTRL_CLK has period 8 CLOCKs, duty 50%, and first rises 4 CLOCKs after reset deasserts.
- Bench controller model (END 33 cycles after GO, ACK=000) -> 10 transfers in order, I2C_DATA = 0x34001A ... 0x341201. DONE=1 and BUSY=0 after the 10th; GO low ≥2 ticks between transfers.
- ACK=3'b010 on the first attempt of entry 4, then 000 -> entry 4 is sent twice with the same I2C_DATA 0x3408F8, then DONE=1 and ERROR=0.
- ACK=3'b001 on all attempts of entry 2 -> 4 attempts (1 + MAX_RETRY), then ERROR=1, INDEX=2, DONE=0, GO=0. A RECONFIG pulse then restarts at INDEX 0.
- RESET asserted during entry 6 XFER -> GO=0 on the same edge, INDEX=0, DONE=0, and the sequence restarts. A RECONFIG pulse while BUSY is ignored.
- With CODEC_POWERUP_DELAY_EN and POWERUP_TICKS=5 -> the first GO rises on tick 8 (5 hold + 2 gap + 1). Without the macro -> tick 4.
